fpga_spi_cmd_tx: RTL

// - SPI command master: the transmitting end of the FPGA configuration link (spck/mosi/ncs).
// - Serialises 16-bit FPGA_CMD words (bits[15:12] opcode: 0001 SET_CONFREG, 0010 SET_DIVISOR;

---
 rtl/fpga_spi_cmd_tx.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/fpga_spi_cmd_tx.sv
// fpga_spi_cmd_tx: SPI command master for the FPGA configuration link.
// Serialises WORD_W-bit command words MSB first on spck/mosi framed by ncs.
// Optional miso capture is enabled by defining FPGA_SPI_CMD_TX_MISO_CAPTURE_EN;
// without it rx_word is tied to zero and miso is ignored.
module fpga_spi_cmd_tx #(
  parameter int WORD_W  = 16,
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 2
) (
  input  logic              ck_1356meg,
  input  logic              nreset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WORD_W-1:0] cmd_word,
  output logic              spck,
  output logic              mosi,
  output logic              ncs,
  input  logic              miso,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rx_word
);

  localparam int BW = $clog2(WORD_W);
  localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0]    GAP_LAST = 8'(GAP_CYC - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_HOLD,
    S_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          divcnt_q, divcnt_d;
  logic [7:0]          gapcnt_q, gapcnt_d;
  logic [BW-1:0]       bitcnt_q, bitcnt_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic                spck_q, spck_d;
  logic                mosi_q, mosi_d;
  logic                ncs_q, ncs_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef FPGA_SPI_CMD_TX_MISO_CAPTURE_EN
  logic [WORD_W-1:0]   rx_shreg_q, rx_shreg_d;
  logic [WORD_W-1:0]   rx_word_q, rx_word_d;
`endif

  // Next-state and registered-output logic for the frame sequencer.
  always_comb begin
    state_d     = state_q;
    divcnt_d    = divcnt_q;
    gapcnt_d    = gapcnt_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    spck_d      = spck_q;
    mosi_d      = mosi_q;
    ncs_d       = ncs_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef FPGA_SPI_CMD_TX_MISO_CAPTURE_EN
    rx_shreg_d  = rx_shreg_q;
    rx_word_d   = rx_word_q;
`endif
    case (state_q)
      S_IDLE: begin
        // cmd_word is only looked at here, so changes while busy are ignored.
        if (cmd_valid && cmd_ready_q) begin
          ncs_d       = 1'b0;
          mosi_d      = cmd_word[WORD_W-1];
          shreg_d     = cmd_word;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          divcnt_d    = DIV_LAST;
          bitcnt_d    = BIT_LAST;
          state_d     = S_LOW;
        end
      end
      S_LOW: begin
        if (divcnt_q == 8'd0) begin
          spck_d   = 1'b1;
          divcnt_d = DIV_LAST;
          state_d  = S_HIGH;
`ifdef FPGA_SPI_CMD_TX_MISO_CAPTURE_EN
          rx_shreg_d = {rx_shreg_q[WORD_W-2:0], miso};
`endif
        end else begin
          divcnt_d = divcnt_q - 8'd1;
        end
      end
      S_HIGH: begin
        if (divcnt_q == 8'd0) begin
          spck_d   = 1'b0;
          divcnt_d = DIV_LAST;
          if (bitcnt_q == '0) begin
            state_d = S_HOLD;
          end else begin
            // mosi moves on the falling spck edge, giving a full half-period
            // of setup before the next rise.
            bitcnt_d = bitcnt_q - BW'(1);
            shreg_d  = shreg_q << 1;
            mosi_d   = shreg_q[WORD_W-2];
            state_d  = S_LOW;
          end
        end else begin
          divcnt_d = divcnt_q - 8'd1;
        end
      end
      S_HOLD: begin
        if (divcnt_q == 8'd0) begin
          ncs_d    = 1'b1;
          done_d   = 1'b1;
          mosi_d   = 1'b0;
          gapcnt_d = GAP_LAST;
          state_d  = S_GAP;
`ifdef FPGA_SPI_CMD_TX_MISO_CAPTURE_EN
          rx_word_d = rx_shreg_q;
`endif
        end else begin
          divcnt_d = divcnt_q - 8'd1;
        end
      end
      S_GAP: begin
        if (gapcnt_q == 8'd0) begin
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end else begin
          gapcnt_d = gapcnt_q - 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset forces idle line levels at once, even mid-frame.
  always_ff @(posedge ck_1356meg) begin
    if (!nreset) begin
      state_q     <= S_IDLE;
      divcnt_q    <= '0;
      gapcnt_q    <= '0;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      spck_q      <= 1'b0;
      mosi_q      <= 1'b0;
      ncs_q       <= 1'b1;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef FPGA_SPI_CMD_TX_MISO_CAPTURE_EN
      rx_shreg_q  <= '0;
      rx_word_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      divcnt_q    <= divcnt_d;
      gapcnt_q    <= gapcnt_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      spck_q      <= spck_d;
      mosi_q      <= mosi_d;
      ncs_q       <= ncs_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef FPGA_SPI_CMD_TX_MISO_CAPTURE_EN
      rx_shreg_q  <= rx_shreg_d;
      rx_word_q   <= rx_word_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign spck      = spck_q;
  assign mosi      = mosi_q;
  assign ncs       = ncs_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef FPGA_SPI_CMD_TX_MISO_CAPTURE_EN
  assign rx_word = rx_word_q;
`else
  // Capture disabled: miso is deliberately left unconnected internally.
  logic unused_miso;
  assign unused_miso = miso;
  assign rx_word     = '0;
`endif

endmodule
